tdm_demux1_4: RTL and testbench
===============================

TDM_DEMUX1_4 -- requirements
Module: tdm_demux1_4

Interface
REQ-001 SHALL have parameter WIDTH, default 1, giving the bit width of each time slot.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port din, input, WIDTH bits: serial time-multiplexed sample stream, one slot per accepted cycle.
REQ-005 SHALL have port din_valid, input, 1 bit: din carries a slot this cycle.
REQ-006 SHALL have port frame_start, input, 1 bit: qualified by din_valid; marks the current din as slot 0.
REQ-007 SHALL have ports out0, out1, out2, out3, each output, WIDTH bits: registered channel outputs for slots 0-3.
REQ-008 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when out0..out3 update together.
REQ-009 SHALL have port slot_idx, output, 2 bits: index of the next slot expected.
REQ-010 SHALL have port sync_err, output, 1 bit: one-cycle pulse on a framing violation.
REQ-011 SHALL have port locked, output, 1 bit: high while the FSM is in state COLLECT.

Function
REQ-012 SHALL implement FSM states HUNT and COLLECT; all outputs SHALL be registered.
REQ-013 SHALL ignore din and frame_start in cycles where din_valid=0, leaving all state and outputs unchanged except that the pulses SHALL return to 0.
REQ-014 In HUNT, an accepted slot with frame_start=1 SHALL be stored in shadow slot 0, set slot_idx=1 and move the FSM to COLLECT.
REQ-015 In HUNT, an accepted slot with frame_start=0 SHALL be discarded with no sync_err.
REQ-016 In COLLECT with slot_idx in 1..3 and frame_start=0, the slot SHALL be stored in shadow[slot_idx] and slot_idx SHALL increment modulo 4.
REQ-017 On the edge that accepts slot 3, out0..out2 SHALL load shadow 0..2, out3 SHALL load din directly, frame_valid SHALL be 1 in the following cycle, and slot_idx SHALL wrap to 0 (latency 1 clk from the last slot to the outputs).
REQ-018 In COLLECT with slot_idx=0, an accepted slot with frame_start=1 SHALL begin a new frame as in REQ-014 while the FSM stays in COLLECT, so back-to-back frames incur no gap.
REQ-019 In COLLECT with slot_idx=0, an accepted slot with frame_start=0 SHALL pulse sync_err, discard the slot and return the FSM to HUNT.
REQ-020 In COLLECT with slot_idx in 1..3, an accepted slot with frame_start=1 SHALL pulse sync_err, discard the partial frame, store the slot as slot 0 and set slot_idx=1 (resync, FSM stays in COLLECT).
REQ-021 On any sync_err, out0..out3 SHALL keep the previous complete frame and frame_valid SHALL stay 0.
REQ-022 frame_valid and sync_err SHALL never both be 1 in the same cycle.

Reset
REQ-023 While rst=1, regardless of clk: FSM=HUNT, slot_idx=0, out0..out3=0, shadow=0, frame_valid=0, sync_err=0, locked=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after rst falls, the first frame SHALL require a frame_start.

Verification
REQ-025 Reset, then slots 1,0,1,1 with frame_start on the first slot and din_valid=1 each cycle -> one cycle after the 4th slot: out0..out3=1,0,1,1 and frame_valid=1 for exactly 1 cycle.
REQ-026 Same frame with din_valid=0 inserted between slots 1 and 2 for 3 cycles -> identical outputs, and frame_valid is delayed by 3 cycles.
REQ-027 frame_start asserted on slot 2 of a frame -> sync_err pulses once, slot_idx=1, outputs unchanged; the following 3 slots complete the new frame.
REQ-028 After a complete frame, a slot arrives with frame_start=0 -> sync_err=1, locked=0; the following slots without frame_start are ignored.
REQ-029 Two back-to-back frames 0,1,0,0 then 1,1,1,0 -> frame_valid pulses 4 cycles apart and the outputs show each frame in order.
REQ-030 rst asserted after 2 slots of a frame, between clock edges -> all outputs are 0 immediately and the remaining slots without frame_start produce no frame_valid.

Source files
------------

// File: rtl/tdm_demux1_4.sv
// -----------------------------------------------------------------------------
// tdm_demux1_4
//
// Splits a serial time-division-multiplexed stream into four parallel channels.
// The receiver hunts for a frame_start marker. It then collects slots 0..3 into
// a shadow store. When the fourth slot arrives, all four channel outputs update
// together in one edge.
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   din          : serial slot data, WIDTH bits
//   din_valid    : din carries a slot this cycle; when low, din and frame_start are ignored
//   frame_start  : qualified by din_valid, marks din as slot 0
//   out0..out3   : registered channel outputs, last complete frame
//   frame_valid  : one-cycle pulse when out0..out3 have just updated
//   slot_idx     : index of the next slot expected
//   sync_err     : one-cycle pulse on a framing violation
//   locked       : high while the receiver is aligned to a frame (COLLECT)
// -----------------------------------------------------------------------------
module tdm_demux1_4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic [1:0]       slot_idx,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_r;
  logic [1:0]       slot_idx_r;
  // Slot 3 needs no shadow entry: it goes straight from din to out3.
  logic [WIDTH-1:0] shadow0_r;
  logic [WIDTH-1:0] shadow1_r;
  logic [WIDTH-1:0] shadow2_r;
  logic [WIDTH-1:0] out0_r;
  logic [WIDTH-1:0] out1_r;
  logic [WIDTH-1:0] out2_r;
  logic [WIDTH-1:0] out3_r;
  logic             frame_valid_r;
  logic             sync_err_r;
  logic             locked_r;

  // Framing FSM: slot capture, frame publication, error pulses and lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= HUNT;
      slot_idx_r    <= 2'd0;
      shadow0_r     <= {WIDTH{1'b0}};
      shadow1_r     <= {WIDTH{1'b0}};
      shadow2_r     <= {WIDTH{1'b0}};
      out0_r        <= {WIDTH{1'b0}};
      out1_r        <= {WIDTH{1'b0}};
      out2_r        <= {WIDTH{1'b0}};
      out3_r        <= {WIDTH{1'b0}};
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      // The pulse outputs stay high for one cycle only.
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      if (din_valid) begin
        case (state_r)
          HUNT: begin
            if (frame_start) begin
              shadow0_r  <= din;
              slot_idx_r <= 2'd1;
              state_r    <= COLLECT;
              locked_r   <= 1'b1;
            end else begin
              // Unaligned data is dropped silently while hunting.
              slot_idx_r <= 2'd0;
            end
          end
          COLLECT: begin
            if (frame_start) begin
              // A marker inside a frame is a resync. It abandons the partial
              // frame but is not lost, because this slot becomes slot 0.
              if (slot_idx_r != 2'd0) begin
                sync_err_r <= 1'b1;
              end else begin
                sync_err_r <= 1'b0;
              end
              shadow0_r  <= din;
              slot_idx_r <= 2'd1;
            end else if (slot_idx_r == 2'd0) begin
              // Slot 0 was expected but no marker came, so alignment is lost.
              sync_err_r <= 1'b1;
              state_r    <= HUNT;
              locked_r   <= 1'b0;
            end else begin
              case (slot_idx_r)
                2'd1: begin
                  shadow1_r  <= din;
                  slot_idx_r <= 2'd2;
                end
                2'd2: begin
                  shadow2_r  <= din;
                  slot_idx_r <= 2'd3;
                end
                2'd3: begin
                  out0_r        <= shadow0_r;
                  out1_r        <= shadow1_r;
                  out2_r        <= shadow2_r;
                  out3_r        <= din;
                  frame_valid_r <= 1'b1;
                  slot_idx_r    <= 2'd0;
                end
                default: begin
                  slot_idx_r <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state_r    <= HUNT;
            slot_idx_r <= 2'd0;
            locked_r   <= 1'b0;
          end
        endcase
      end else begin
        // An idle cycle holds all state. Only the pulses above fall back to 0.
        state_r <= state_r;
      end
    end
  end

  assign out0        = out0_r;
  assign out1        = out1_r;
  assign out2        = out2_r;
  assign out3        = out3_r;
  assign frame_valid = frame_valid_r;
  assign slot_idx    = slot_idx_r;
  assign sync_err    = sync_err_r;
  assign locked      = locked_r;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// Directed testbench for tdm_demux1_4 (WIDTH=4) with hand-computed expectations.
module tb_tdm_demux1_4;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_start;
  logic [W-1:0] out0, out1, out2, out3;
  logic         frame_valid;
  logic [1:0]   slot_idx;
  logic         sync_err;
  logic         locked;

  int pass_cnt = 0;
  int total_cnt = 0;

  tdm_demux1_4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .slot_idx    (slot_idx),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check every output against the expected values.
  task automatic expect_all(input string tag, input logic [15:0] frame, input logic fv,
                            input logic se, input logic [1:0] idx, input logic lk);
    chk({tag, ".outs"},   {out0, out1, out2, out3}, frame);
    chk({tag, ".fvalid"}, {15'd0, frame_valid}, {15'd0, fv});
    chk({tag, ".syncerr"},{15'd0, sync_err}, {15'd0, se});
    chk({tag, ".idx"},    {14'd0, slot_idx}, {14'd0, idx});
    chk({tag, ".locked"}, {15'd0, locked}, {15'd0, lk});
  endtask

  // Apply one cycle of input, then sample 1 time unit after the rising edge.
  task automatic step(input logic [W-1:0] d, input logic v, input logic fs);
    din = d;
    din_valid = v;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    din = 4'h0;
    din_valid = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_all("reset", 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Basic frame 1,0,1,1.
    step(4'h1, 1'b1, 1'b1); expect_all("f1s0", 16'h0000, 1'b0, 1'b0, 2'd1, 1'b1);
    step(4'h0, 1'b1, 1'b0); expect_all("f1s1", 16'h0000, 1'b0, 1'b0, 2'd2, 1'b1);
    step(4'h1, 1'b1, 1'b0); expect_all("f1s2", 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1);
    step(4'h1, 1'b1, 1'b0); expect_all("f1s3", 16'h1011, 1'b1, 1'b0, 2'd0, 1'b1);
    step(4'h0, 1'b0, 1'b0); expect_all("f1idle", 16'h1011, 1'b0, 1'b0, 2'd0, 1'b1);

    // The same frame with 3 invalid cycles after slot 1. The garbage on din and
    // frame_start during those cycles must be ignored.
    step(4'h1, 1'b1, 1'b1); expect_all("f2s0", 16'h1011, 1'b0, 1'b0, 2'd1, 1'b1);
    step(4'h0, 1'b1, 1'b0); expect_all("f2s1", 16'h1011, 1'b0, 1'b0, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b0, 1'b1); expect_all("f2gap", 16'h1011, 1'b0, 1'b0, 2'd2, 1'b1);
    end
    step(4'h1, 1'b1, 1'b0); expect_all("f2s2", 16'h1011, 1'b0, 1'b0, 2'd3, 1'b1);
    step(4'h1, 1'b1, 1'b0); expect_all("f2s3", 16'h1011, 1'b1, 1'b0, 2'd0, 1'b1);

    // Back-to-back frames 0,1,0,0 and 1,1,1,0 with no gap between them.
    step(4'h0, 1'b1, 1'b1); expect_all("b1s0", 16'h1011, 1'b0, 1'b0, 2'd1, 1'b1);
    step(4'h1, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0); expect_all("b1s3", 16'h0100, 1'b1, 1'b0, 2'd0, 1'b1);
    step(4'h1, 1'b1, 1'b1); expect_all("b2s0", 16'h0100, 1'b0, 1'b0, 2'd1, 1'b1);
    step(4'h1, 1'b1, 1'b0); expect_all("b2s1", 16'h0100, 1'b0, 1'b0, 2'd2, 1'b1);
    step(4'h1, 1'b1, 1'b0); expect_all("b2s2", 16'h0100, 1'b0, 1'b0, 2'd3, 1'b1);
    step(4'h0, 1'b1, 1'b0); expect_all("b2s3", 16'h1110, 1'b1, 1'b0, 2'd0, 1'b1);

    // A frame of distinct values checks the slot-to-channel order.
    step(4'hA, 1'b1, 1'b1);
    step(4'hB, 1'b1, 1'b0);
    step(4'hC, 1'b1, 1'b0);
    step(4'hD, 1'b1, 1'b0); expect_all("ord", 16'hABCD, 1'b1, 1'b0, 2'd0, 1'b1);

    // A marker on slot 2 resyncs: the partial frame 5,6 is dropped and 7 becomes slot 0.
    step(4'h5, 1'b1, 1'b1);
    step(4'h6, 1'b1, 1'b0);
    step(4'h7, 1'b1, 1'b1); expect_all("rsync", 16'hABCD, 1'b0, 1'b1, 2'd1, 1'b1);
    step(4'h8, 1'b1, 1'b0); expect_all("rs1", 16'hABCD, 1'b0, 1'b0, 2'd2, 1'b1);
    step(4'h9, 1'b1, 1'b0); expect_all("rs2", 16'hABCD, 1'b0, 1'b0, 2'd3, 1'b1);
    step(4'hE, 1'b1, 1'b0); expect_all("rs3", 16'h789E, 1'b1, 1'b0, 2'd0, 1'b1);

    // A missing marker on slot 0 loses lock. Slots that follow without a marker
    // are ignored, and so is a marker on an invalid cycle.
    step(4'h3, 1'b1, 1'b0); expect_all("lost", 16'h789E, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'h4, 1'b1, 1'b0); expect_all("hunt", 16'h789E, 1'b0, 1'b0, 2'd0, 1'b0);
    end
    step(4'h5, 1'b0, 1'b1); expect_all("huntinv", 16'h789E, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset raised between clock edges after 2 slots of a frame.
    step(4'h1, 1'b1, 1'b1);
    step(4'h2, 1'b1, 1'b0); expect_all("prerst", 16'h789E, 1'b0, 1'b0, 2'd2, 1'b1);
    #2 rst = 1'b1;
    #1 expect_all("asyncrst", 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'h3, 1'b1, 1'b0); expect_all("postrst1", 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'h4, 1'b1, 1'b0); expect_all("postrst2", 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // After the reset, a full frame with a marker is received normally.
    step(4'h1, 1'b1, 1'b1);
    step(4'h2, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    step(4'h4, 1'b1, 1'b0); expect_all("recover", 16'h1234, 1'b1, 1'b0, 2'd0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
